// File: rtl/code_conv_arbiter.sv
// Round-robin arbiter sharing one registered binary<->Gray converter
// among NREQ requesters, with a single-entry result register.
module code_conv_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_mode,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_mode,
    output logic [15:0]           conv_count
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t state, state_nxt;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt;
    logic [NREQ-1:0]  gnt_oh;
    logic             found;
    logic [WIDTH-1:0] sel_data;
    logic             sel_mode;
    logic             can_accept;
    logic             accept;

    function automatic logic [WIDTH-1:0] conv(
        input logic [WIDTH-1:0] x,
        input logic             m
    );
        logic [WIDTH-1:0] b;
        b = x;
        if (!m) begin
            b = x ^ (x >> 1);
        end else begin
            for (int k = WIDTH - 2; k >= 0; k--) begin
                b[k] = b[k+1] ^ x[k];
            end
        end
        return b;
    endfunction

    // Search from rr_ptr upward, wrapping; first valid requester wins.
    always_comb begin
        int idx;
        found    = 1'b0;
        gnt      = '0;
        gnt_oh   = '0;
        sel_data = '0;
        sel_mode = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                gnt         = IDW'(idx);
                gnt_oh[idx] = 1'b1;
                sel_data    = req_data[idx*WIDTH +: WIDTH];
                sel_mode    = req_mode[idx];
            end
        end
    end

    assign can_accept = (state == EMPTY) || rsp_ready;
    assign req_ready  = can_accept ? gnt_oh : '0;
    assign accept     = found && can_accept;
    assign rsp_valid  = (state == FULL);

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (rsp_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_mode   <= 1'b0;
            rr_ptr     <= '0;
            conv_count <= '0;
        end else if (accept) begin
            rsp_data <= conv(sel_data, sel_mode);
            rsp_id   <= gnt;
            rsp_mode <= sel_mode;
            rr_ptr   <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            if (conv_count != 16'hFFFF) begin
                conv_count <= conv_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_code_conv_arbiter.sv
// Directed self-checking bench for code_conv_arbiter (WIDTH=4, NREQ=2).
module tb_code_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_data;
    logic [1:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_data;
    logic [0:0]  rsp_id;
    logic        rsp_mode;
    logic [15:0] conv_count;

    int checks = 0;
    int errors = 0;

    code_conv_arbiter #(.WIDTH(4), .NREQ(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_mode(req_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_mode(rsp_mode), .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        req_data = 8'h00;
        req_mode = 2'b00;
        rsp_ready = 1'b1;
        #3;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== 7'd0) begin
            errors++;
            $display("FAIL reset_rsp: got %b expected 0000000",
                     {rsp_valid, rsp_data, rsp_id, rsp_mode});
        end
        checks++;
        if (conv_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_count: got %h expected 0000", conv_count);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 00", req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_b2g();
        req_data = 8'b0000_1011;
        req_mode = 2'b00;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL b2g_ready: got %b expected 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode} !== {1'b1, 4'b1110, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2g_rsp: got %b expected 1111000",
                     {rsp_valid, rsp_data, rsp_id, rsp_mode});
        end
        checks++;
        if (conv_count !== 16'd1) begin
            errors++;
            $display("FAIL b2g_count: got %0d expected 1", conv_count);
        end
    endtask

    task automatic test_g2b();
        req_data = 8'b1110_0000;
        req_mode = 2'b10;
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL g2b_ready: got %b expected 10", req_ready);
        end
        step();
        checks++;
        if ({rsp_data, rsp_id, rsp_mode} !== {4'b1011, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL g2b_rsp1: got %b expected 101111",
                     {rsp_data, rsp_id, rsp_mode});
        end
        req_data = 8'b1000_0000;
        step();
        req_valid = 2'b00;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 4'b1111, 1'b1}) begin
            errors++;
            $display("FAIL g2b_rsp2: got %b expected 111111",
                     {rsp_valid, rsp_data, rsp_id});
        end
        step();
        checks++;
        if ({rsp_valid, rsp_data, conv_count} !== {1'b0, 4'b1111, 16'd3}) begin
            errors++;
            $display("FAIL drain_hold: got v=%b d=%b c=%0d expected v=0 d=1111 c=3",
                     rsp_valid, rsp_data, conv_count);
        end
    endtask

    task automatic test_alternate();
        logic [0:0] exp_id;
        logic [3:0] exp_d;
        req_data = 8'b0011_0001;
        req_mode = 2'b10;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_id = 1'(i % 2);
            exp_d = exp_id ? 4'b0010 : 4'b0001;
            #1;
            checks++;
            if (req_ready !== (exp_id ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL alt_ready[%0d]: got %b expected id %0d",
                         i, req_ready, exp_id);
            end
            step();
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, conv_count} !==
                {1'b1, exp_id, exp_d, 16'(4 + i)}) begin
                errors++;
                $display("FAIL alt_rsp[%0d]: got v=%b id=%0d d=%b c=%0d expected v=1 id=%0d d=%b c=%0d",
                         i, rsp_valid, rsp_id, rsp_data, conv_count,
                         exp_id, exp_d, 4 + i);
            end
        end
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({req_ready, rsp_valid, rsp_id, rsp_data, conv_count} !==
                {2'b00, 1'b1, 1'b1, 4'b0010, 16'd7}) begin
                errors++;
                $display("FAIL stall[%0d]: got rdy=%b v=%b id=%0d d=%b c=%0d expected rdy=00 v=1 id=1 d=0010 c=7",
                         i, req_ready, rsp_valid, rsp_id, rsp_data, conv_count);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL stall_release_ready: got %b expected 01", req_ready);
        end
        step();
        checks++;
        if ({rsp_id, rsp_data, conv_count} !== {1'b0, 4'b0001, 16'd8}) begin
            errors++;
            $display("FAIL stall_release_rsp: got id=%0d d=%b c=%0d expected id=0 d=0001 c=8",
                     rsp_id, rsp_data, conv_count);
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_mode, conv_count} !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b d=%b id=%0d m=%b c=%0d expected all zero",
                     rsp_valid, rsp_data, rsp_id, rsp_mode, conv_count);
        end
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_ptr: got ready %b expected 01", req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
    endtask

    task automatic test_sweep();
        logic [3:0] g;
        logic [3:0] w;
        req_valid = 2'b01;
        for (int i = 0; i < 16; i++) begin
            w = 4'(i);
            req_data = {4'b0000, w};
            req_mode = 2'b00;
            step();
            g = rsp_data;
            checks++;
            if (g !== (w ^ (w >> 1))) begin
                errors++;
                $display("FAIL sweep_b2g[%0d]: got %b expected %b", i, g, w ^ (w >> 1));
            end
            req_data = {4'b0000, g};
            req_mode = 2'b01;
            step();
            checks++;
            if ({rsp_data, rsp_mode} !== {w, 1'b1}) begin
                errors++;
                $display("FAIL sweep_g2b[%0d]: got %b m=%b expected %b m=1",
                         i, rsp_data, rsp_mode, w);
            end
        end
        checks++;
        if (conv_count !== 16'd32) begin
            errors++;
            $display("FAIL sweep_count: got %0d expected 32", conv_count);
        end
    endtask

    task automatic test_saturate();
        req_valid = 2'b01;
        for (int n = 0; n < 70000 && conv_count !== 16'hFFFF; n++) begin
            step();
        end
        checks++;
        if (conv_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: got %h expected ffff", conv_count);
        end
        for (int n = 0; n < 3; n++) begin
            step();
        end
        checks++;
        if ({rsp_valid, conv_count} !== {1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL sat_hold: got v=%b c=%h expected v=1 c=ffff",
                     rsp_valid, conv_count);
        end
        req_valid = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_b2g();
        test_g2b();
        test_alternate();
        test_stall();
        test_reset_mid();
        test_sweep();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
